// File: rtl/button_cmd_ctrl_if.sv
// Command handshake between the button controller and the player-movement FSM.
interface button_cmd_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;
    logic       cmd_repeat;

    modport master (output cmd_valid, output cmd_code, output cmd_repeat, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, input cmd_repeat, output cmd_ready);
endinterface

// File: rtl/button_cmd_ctrl.sv
// Push-button front end: synchronize, debounce, and turn levels into one-shot,
// auto-repeat and bomb commands presented on a valid/ready handshake.
module button_cmd_ctrl #(
    parameter int N_BTN        = 5,
    parameter int DB_CYCLES    = 200000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BTN-1:0]     btn_raw,
    button_cmd_ctrl_if.master    cmd,
    output logic [3:0]           held_dir,
    output logic [N_BTN-1:0]     db_state
);
    localparam int CW   = $clog2(DB_CYCLES + 1);
    localparam int TW   = $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam int BOMB = 4;

    localparam logic [CW-1:0] DB_MAX     = CW'(DB_CYCLES);
    localparam logic [CW-1:0] DB_PRE     = CW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [N_BTN-1:0] sync1_r, sync2_r, db_r;
    logic [CW-1:0]    cnt_r [N_BTN];
    logic             bomb_prev_r, bomb_rise_s;

    logic [1:0]    state_r, state_s;
    logic [1:0]    dir_sel_r, dir_sel_s, low_dir_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [3:0]    dir_db_s, held_dir_r;
    logic          issue_s, issue_rep_s;

    logic          bomb_pend_r, dir_pend_r, dir_rep_r, load_s;
    logic [1:0]    dir_code_r;
    logic          valid_r, repeat_r;
    logic [2:0]    code_r;

    // Two-flop synchronizer feeding saturating per-button debounce counters;
    // db_r is registered to equal (cnt == DB_CYCLES) in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
            db_r    <= '0;
            for (int i = 0; i < N_BTN; i++) cnt_r[i] <= '0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            for (int i = 0; i < N_BTN; i++) begin
                if (!sync2_r[i]) begin
                    cnt_r[i] <= '0;
                    db_r[i]  <= 1'b0;
                end else if (cnt_r[i] < DB_MAX) begin
                    cnt_r[i] <= cnt_r[i] + 1'b1;
                    db_r[i]  <= (cnt_r[i] == DB_PRE);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                    db_r[i]  <= 1'b1;
                end
            end
        end
    end

    assign bomb_rise_s = db_r[BOMB] & ~bomb_prev_r;
    assign dir_db_s    = db_r[3:0];

    // Lowest-index debounced direction wins when several are down in IDLE.
    always_comb begin
        low_dir_s = 2'd3;
        if (dir_db_s[0]) begin
            low_dir_s = 2'd0;
        end else if (dir_db_s[1]) begin
            low_dir_s = 2'd1;
        end else if (dir_db_s[2]) begin
            low_dir_s = 2'd2;
        end else begin
            low_dir_s = 2'd3;
        end
    end

    // Direction FSM next state; release beats a simultaneous timer expiry.
    always_comb begin
        state_s     = state_r;
        dir_sel_s   = dir_sel_r;
        timer_s     = timer_r;
        issue_s     = 1'b0;
        issue_rep_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|dir_db_s) begin
                    dir_sel_s = low_dir_s;
                    issue_s   = 1'b1;
                    timer_s   = '0;
                    state_s   = ST_DELAY;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!dir_db_s[dir_sel_r]) begin
                    timer_s = '0;
                    state_s = ST_IDLE;
                end else if (timer_r == ((state_r == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                    issue_s     = 1'b1;
                    issue_rep_s = 1'b1;
                    timer_s     = '0;
                    state_s     = ST_REPEAT;
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
            default: begin
                timer_s = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Direction FSM state, bomb edge history and sprite-facing output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            dir_sel_r   <= 2'd0;
            timer_r     <= '0;
            held_dir_r  <= 4'd0;
            bomb_prev_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            dir_sel_r   <= dir_sel_s;
            timer_r     <= timer_s;
            held_dir_r  <= (state_s != ST_IDLE) ? (4'b0001 << dir_sel_s) : 4'd0;
            bomb_prev_r <= db_r[BOMB];
        end
    end

    assign load_s = !valid_r || cmd.cmd_ready;

    // Single-entry pendings (newer issue overwrites) and the output register;
    // a fresh event arriving as its pending is loaded stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            bomb_pend_r <= 1'b0;
            dir_pend_r  <= 1'b0;
            dir_code_r  <= 2'd0;
            dir_rep_r   <= 1'b0;
            valid_r     <= 1'b0;
            code_r      <= 3'd0;
            repeat_r    <= 1'b0;
        end else begin
            if (bomb_rise_s) begin
                bomb_pend_r <= 1'b1;
            end else if (load_s && bomb_pend_r) begin
                bomb_pend_r <= 1'b0;
            end else begin
                bomb_pend_r <= bomb_pend_r;
            end

            if (issue_s) begin
                dir_pend_r <= 1'b1;
                dir_code_r <= dir_sel_s;
                dir_rep_r  <= issue_rep_s;
            end else if (load_s && !bomb_pend_r && dir_pend_r) begin
                dir_pend_r <= 1'b0;
            end else begin
                dir_pend_r <= dir_pend_r;
            end

            if (load_s) begin
                if (bomb_pend_r) begin
                    valid_r  <= 1'b1;
                    code_r   <= 3'd4;
                    repeat_r <= 1'b0;
                end else if (dir_pend_r) begin
                    valid_r  <= 1'b1;
                    code_r   <= {1'b0, dir_code_r};
                    repeat_r <= dir_rep_r;
                end else begin
                    valid_r  <= 1'b0;
                end
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign cmd.cmd_valid  = valid_r;
    assign cmd.cmd_code   = code_r;
    assign cmd.cmd_repeat = repeat_r;
    assign held_dir       = held_dir_r;
    assign db_state       = db_r;
endmodule

// File: tb/tb_button_cmd_ctrl.sv
// Self-checking bench for button_cmd_ctrl with short debounce/repeat timings.
module tb_button_cmd_ctrl;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn_raw = 5'd0;
    logic [3:0] held_dir;
    logic [4:0] db_state;

    button_cmd_ctrl_if cif ();

    button_cmd_ctrl #(
        .N_BTN(5), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .cmd(cif.master),
        .held_dir(held_dir), .db_state(db_state)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [2:0] code; logic rep; } exp_t;
    typedef struct { logic [4:0] btn; logic [4:0] db; logic valid; logic [3:0] held; } vec_t;

    exp_t sb_q[$];
    vec_t vecs[20];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [2:0] code, input logic rep);
        exp_t e;
        e.cyc = c; e.code = code; e.rep = rep;
        sb_q.push_back(e);
    endtask

    // Score any accepted command in the current cycle, then advance one cycle.
    task automatic tick();
        exp_t e;
        if (cif.cmd_valid === 1'b1 && cif.cmd_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd at cycle %0d: got code %0d repeat %0d expected none",
                         cyc, cif.cmd_code, cif.cmd_repeat);
            end else begin
                e = sb_q.pop_front();
                chk("cmd_cycle", 32'(cyc), 32'(e.cyc));
                chk("cmd_code", 32'(cif.cmd_code), 32'(e.code));
                chk("cmd_repeat", 32'(cif.cmd_repeat), 32'(e.rep));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        btn_raw = 5'd0;
        cif.cmd_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic finish_scn(input int last);
        while (cyc < last) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        for (int c = 0; c < 20; c++) begin
            vecs[c].btn   = (c < 12) ? 5'b00100 : 5'b00000;
            vecs[c].db    = (c >= 6 && c <= 14) ? 5'b00100 : 5'b00000;
            vecs[c].valid = (c == 8);
            vecs[c].held  = (c >= 7 && c <= 15) ? 4'b0100 : 4'b0000;
        end

        // Reset state
        do_reset();
        chk("rst_valid", 32'(cif.cmd_valid), 32'd0);
        chk("rst_code", 32'(cif.cmd_code), 32'd0);
        chk("rst_repeat", 32'(cif.cmd_repeat), 32'd0);
        chk("rst_held", 32'(held_dir), 32'd0);
        chk("rst_db", 32'(db_state), 32'd0);

        // Bounce rejection: 3 high / 1 low never reaches the debounce count
        do_reset();
        while (cyc < 40) begin
            btn_raw = (cyc % 4 != 3) ? 5'b00001 : 5'b00000;
            chk("bounce_db", 32'(db_state[0]), 32'd0);
            chk("bounce_valid", 32'(cif.cmd_valid), 32'd0);
            tick();
        end
        btn_raw = 5'd0;
        finish_scn(50);

        // Clean press, table driven
        do_reset();
        push(8, 3'd2, 1'b0);
        for (int c = 0; c < 20; c++) begin
            btn_raw = vecs[c].btn;
            chk("press_db", 32'(db_state), 32'(vecs[c].db));
            chk("press_valid", 32'(cif.cmd_valid), 32'(vecs[c].valid));
            chk("press_held", 32'(held_dir), 32'(vecs[c].held));
            tick();
        end
        finish_scn(30);

        // Auto-repeat; release timed so a repeat expiry meets the release
        do_reset();
        push(8, 3'd1, 1'b0);
        push(18, 3'd1, 1'b1);
        push(23, 3'd1, 1'b1);
        push(28, 3'd1, 1'b1);
        push(33, 3'd1, 1'b1);
        push(38, 3'd1, 1'b1);
        while (cyc < 60) begin
            btn_raw = (cyc < 38) ? 5'b00010 : 5'b00000;
            tick();
        end
        finish_scn(60);

        // Bomb priority under backpressure, coalesced direction repeat
        do_reset();
        push(20, 3'd4, 1'b0);
        push(21, 3'd0, 1'b1);
        push(23, 3'd0, 1'b1);
        while (cyc < 45) begin
            btn_raw = (cyc < 21) ? 5'b10001 : 5'b00000;
            cif.cmd_ready = (cyc >= 20);
            if (cyc >= 8 && cyc <= 20) begin
                chk("bp_valid", 32'(cif.cmd_valid), 32'd1);
                chk("bp_code", 32'(cif.cmd_code), 32'd4);
                chk("bp_repeat", 32'(cif.cmd_repeat), 32'd0);
            end
            tick();
        end
        finish_scn(45);

        // Simultaneous directions, then reselect after the lower one releases
        do_reset();
        push(8, 3'd1, 1'b0);
        push(16, 3'd3, 1'b0);
        while (cyc < 40) begin
            btn_raw = (cyc < 10) ? 5'b01010 : ((cyc < 17) ? 5'b01000 : 5'b00000);
            if (cyc == 8)  chk("simul_held_down", 32'(held_dir), 32'b0010);
            if (cyc == 16) chk("simul_held_right", 32'(held_dir), 32'b1000);
            tick();
        end
        finish_scn(40);

        // Reset mid-hold with a stalled command
        do_reset();
        cif.cmd_ready = 1'b0;
        push(24, 3'd0, 1'b0);
        while (cyc < 40) begin
            btn_raw = (cyc < 26) ? 5'b00001 : 5'b00000;
            reset = (cyc == 15);
            cif.cmd_ready = (cyc >= 24);
            if (cyc == 8) chk("mid_pre_valid", 32'(cif.cmd_valid), 32'd1);
            if (cyc == 16) begin
                chk("mid_rst_held", 32'(held_dir), 32'd0);
                chk("mid_rst_db", 32'(db_state), 32'd0);
            end
            if (cyc >= 16 && cyc <= 23) chk("mid_rst_valid", 32'(cif.cmd_valid), 32'd0);
            if (cyc == 24) chk("mid_next_valid", 32'(cif.cmd_valid), 32'd1);
            tick();
        end
        finish_scn(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
